digit_sequence_generator: RTL and testbench

Stimulus-side counterpart of the digit sequence detector. On request it emits a registered 4-bit BCD digit stream containing a programmable 4-digit target pattern (default 1-0-9-4) a given number of times, separated by pseudo-random filler digits. Filler is constrained so the target never appears by accident. It drives detector inputs in self-checking benches and on-board demos, and also produces the matching expected-hit strobe.

---
 rtl/digit_sequence_generator_if.sv | 30 +++
 rtl/digit_sequence_generator.sv | 140 ++++++++++++++
 tb/tb_digit_sequence_generator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/digit_sequence_generator_if.sv
// Stimulus-side bus of the digit sequence generator: request inputs and the emitted digit stream.
// With ERR_INJECT_EN defined the bus also carries the inject request bit.
interface digit_sequence_generator_if;
   logic       start;
   logic [3:0] burst_count;
`ifdef ERR_INJECT_EN
   logic       inject;
`endif
   logic [3:0] number;
   logic       valid;
   logic       pattern_end;
   logic       busy;
   logic       done;

   modport master (
`ifdef ERR_INJECT_EN
      output inject,
`endif
      output start, burst_count,
      input  number, valid, pattern_end, busy, done
   );

   modport slave (
`ifdef ERR_INJECT_EN
      input  inject,
`endif
      input  start, burst_count,
      output number, valid, pattern_end, busy, done
   );
endinterface

// File: rtl/digit_sequence_generator.sv
// Emits a BCD digit stream holding a 4-digit pattern burst_count times, separated by LFSR filler.
// Optional ERR_INJECT_EN: corrupts the final pattern's last digit when inject was latched at start.
module digit_sequence_generator #(
   parameter logic [3:0] PAT0      = 4'd1,
   parameter logic [3:0] PAT1      = 4'd0,
   parameter logic [3:0] PAT2      = 4'd9,
   parameter logic [3:0] PAT3      = 4'd4,
   parameter int         GAP       = 2,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input logic                        clock,
   input logic                        reset_n,
   digit_sequence_generator_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, GAPS, P0, P1, P2, P3, DONE} state_t;

   localparam logic [3:0] GAP_N    = 4'(GAP);
   localparam logic [3:0] PAT0_ALT = (PAT0 == 4'd9) ? 4'd0 : PAT0 + 4'd1;
   localparam logic [3:0] PAT3_ALT = (PAT3 == 4'd9) ? 4'd0 : PAT3 + 4'd1;

   // Filler never equals PAT0, so the pattern can only start where it is inserted.
   function automatic logic [3:0] filler(input logic [7:0] l);
      logic [3:0] raw;
      raw = l[3:0];
      if (raw > 4'd9) raw = raw - 4'd6;
      if (raw == PAT0) raw = PAT0_ALT;
      return raw;
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   state_t     state;
   logic [7:0] lfsr;
   logic [3:0] gap_cnt;
   logic [4:0] remaining;
   logic       corrupt;

`ifdef ERR_INJECT_EN
   logic inject_q;
   assign corrupt = inject_q && (remaining == 5'd1);
`else
   assign corrupt = 1'b0;
`endif

   // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state           <= IDLE;
         lfsr            <= LFSR_SEED;
         gap_cnt         <= '0;
         remaining       <= '0;
         bus.number      <= 4'hF;
         bus.valid       <= 1'b0;
         bus.pattern_end <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
`ifdef ERR_INJECT_EN
         inject_q        <= 1'b0;
`endif
      end else begin
         bus.pattern_end <= 1'b0;
         bus.done        <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  remaining <= (bus.burst_count == 4'd0) ? 5'd16 : {1'b0, bus.burst_count};
                  gap_cnt   <= '0;
                  bus.busy  <= 1'b1;
                  bus.valid <= 1'b1;
`ifdef ERR_INJECT_EN
                  inject_q  <= bus.inject;
`endif
                  if (GAP_N != 4'd0) begin
                     state      <= GAPS;
                     bus.number <= filler(lfsr);
                     lfsr       <= lfsr_step(lfsr);
                     gap_cnt    <= 4'd1;
                  end else begin
                     state      <= P0;
                     bus.number <= PAT0;
                  end
               end
            end
            GAPS: begin
               if (gap_cnt == GAP_N) begin
                  state      <= P0;
                  bus.number <= PAT0;
               end else begin
                  bus.number <= filler(lfsr);
                  lfsr       <= lfsr_step(lfsr);
                  gap_cnt    <= gap_cnt + 4'd1;
               end
            end
            P0: begin
               state      <= P1;
               bus.number <= PAT1;
            end
            P1: begin
               state      <= P2;
               bus.number <= PAT2;
            end
            P2: begin
               state <= P3;
               if (corrupt) begin
                  bus.number <= PAT3_ALT;
               end else begin
                  bus.number      <= PAT3;
                  bus.pattern_end <= 1'b1;
               end
            end
            P3: begin
               remaining <= remaining - 5'd1;
               if (remaining == 5'd1) begin
                  state      <= DONE;
                  bus.valid  <= 1'b0;
                  bus.number <= 4'hF;
                  bus.done   <= 1'b1;
               end else if (GAP_N != 4'd0) begin
                  state      <= GAPS;
                  bus.number <= filler(lfsr);
                  lfsr       <= lfsr_step(lfsr);
                  gap_cnt    <= 4'd1;
               end else begin
                  state      <= P0;
                  bus.number <= PAT0;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_sequence_generator.sv
// Randomized self-checking bench: two generators (GAP=2 and GAP=0) against a queue-based stream model.
module tb_digit_sequence_generator;
   localparam logic [3:0] PAT0 = 4'd1, PAT1 = 4'd0, PAT2 = 4'd9, PAT3 = 4'd4;
   localparam logic [7:0] SEED = 8'hA5;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   digit_sequence_generator_if if_a ();
   digit_sequence_generator_if if_b ();

   digit_sequence_generator #(.PAT0(PAT0), .PAT1(PAT1), .PAT2(PAT2), .PAT3(PAT3),
                              .GAP(2), .LFSR_SEED(SEED))
      dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a.slave));

   digit_sequence_generator #(.PAT0(PAT0), .PAT1(PAT1), .PAT2(PAT2), .PAT3(PAT3),
                              .GAP(0), .LFSR_SEED(SEED))
      dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b.slave));

   int tests  = 0;
   int failed = 0;
   int burst_id = 0;

   logic [7:0] model_lfsr [2];
   int         gap_of     [2] = '{2, 0};
   logic [4:0] exp_q [$];   // {pattern_end, number}

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] fill(input logic [7:0] l);
      int r;
      r = int'(l[3:0]);
      if (r > 9) r = r - 6;
      if (r == int'(PAT0)) r = (PAT0 == 4'd9) ? 0 : int'(PAT0) + 1;
      return 4'(r);
   endfunction

   task automatic drive(input int sel, input logic s, input logic [3:0] bc, input logic inj);
      if (sel == 0) begin
         if_a.start = s; if_a.burst_count = bc;
`ifdef ERR_INJECT_EN
         if_a.inject = inj;
`endif
      end else begin
         if_b.start = s; if_b.burst_count = bc;
`ifdef ERR_INJECT_EN
         if_b.inject = inj;
`endif
      end
      if (inj === 1'bx) $display("warning: unknown inject");
   endtask

   task automatic sample(input int sel, output logic [3:0] n, output logic v, output logic pe,
                         output logic b, output logic d);
      if (sel == 0) begin
         n = if_a.number; v = if_a.valid; pe = if_a.pattern_end; b = if_a.busy; d = if_a.done;
      end else begin
         n = if_b.number; v = if_b.valid; pe = if_b.pattern_end; b = if_b.busy; d = if_b.done;
      end
   endtask

   // Expected stream for one burst: n instances of GAP fillers followed by the pattern.
   task automatic build(input int sel, input int n, input logic inj);
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         for (int g = 0; g < gap_of[sel]; g++) begin
            exp_q.push_back({1'b0, fill(model_lfsr[sel])});
            model_lfsr[sel] = {model_lfsr[sel][6:0],
                               model_lfsr[sel][7] ^ model_lfsr[sel][5] ^ model_lfsr[sel][4] ^ model_lfsr[sel][3]};
         end
         exp_q.push_back({1'b0, PAT0});
         exp_q.push_back({1'b0, PAT1});
         exp_q.push_back({1'b0, PAT2});
         if (inj && k == n - 1) exp_q.push_back({1'b0, (PAT3 == 4'd9) ? 4'd0 : PAT3 + 4'd1});
         else                   exp_q.push_back({1'b1, PAT3});
      end
   endtask

   task automatic run_burst(input int sel, input logic [3:0] bc, input logic inj,
                            input int abort_at, input bit strays);
      logic [3:0] n; logic v, pe, b, d;
      int inst, hits;
      string t;
      inst = (bc == 4'd0) ? 16 : int'(bc);
      hits = 0;
      burst_id++;
      build(sel, inst, inj);
      drive(sel, 1'b1, bc, inj);
      @(negedge clock);
      drive(sel, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         sample(sel, n, v, pe, b, d);
         if (i == abort_at) begin
            reset_n = 1'b0;
            drive(sel, 1'b0, 4'd0, 1'b0);
            @(negedge clock);
            sample(sel, n, v, pe, b, d);
            t = $sformatf("b%0d_rst", burst_id);
            check({t, "_valid"}, 32'(v), 0);
            check({t, "_num"},   32'(n), 32'hF);
            check({t, "_busy"},  32'(b), 0);
            check({t, "_done"},  32'(d), 0);
            check({t, "_pe"},    32'(pe), 0);
            reset_n = 1'b1;
            model_lfsr[0] = SEED;
            model_lfsr[1] = SEED;
            @(negedge clock);
            return;
         end
         t = $sformatf("b%0d_d%0d", burst_id, i);
         check({t, "_num"},   32'(n), 32'(exp_q[i][3:0]));
         check({t, "_valid"}, 32'(v), 1);
         check({t, "_pe"},    32'(pe), 32'(exp_q[i][4]));
         check({t, "_busy"},  32'(b), 1);
         check({t, "_done"},  32'(d), 0);
         if (pe) hits++;
         if (strays && $urandom_range(0, 3) == 0)
            drive(sel, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         else
            drive(sel, 1'b0, 4'd0, 1'b0);
         @(negedge clock);
      end
      drive(sel, 1'b0, 4'd0, 1'b0);
      sample(sel, n, v, pe, b, d);
      t = $sformatf("b%0d_end", burst_id);
      check({t, "_done"},  32'(d), 1);
      check({t, "_valid"}, 32'(v), 0);
      check({t, "_num"},   32'(n), 32'hF);
      check({t, "_busy"},  32'(b), 1);
      check({t, "_pe"},    32'(pe), 0);
      check({t, "_hits"},  32'(hits), 32'(inst - (inj ? 1 : 0)));
      @(negedge clock);
      sample(sel, n, v, pe, b, d);
      check({t, "_idle_done"}, 32'(d), 0);
      check({t, "_idle_busy"}, 32'(b), 0);
      check({t, "_idle_valid"}, 32'(v), 0);
   endtask

   initial begin
      logic [3:0] n; logic v, pe, b, d;
      logic inj;
      reset_n = 1'b0;
      drive(0, 1'b0, 4'd0, 1'b0);
      drive(1, 1'b0, 4'd0, 1'b0);
      model_lfsr[0] = SEED;
      model_lfsr[1] = SEED;
      repeat (3) @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         sample(s, n, v, pe, b, d);
         check($sformatf("rst%0d_num", s),   32'(n), 32'hF);
         check($sformatf("rst%0d_valid", s), 32'(v), 0);
         check($sformatf("rst%0d_pe", s),    32'(pe), 0);
         check($sformatf("rst%0d_busy", s),  32'(b), 0);
         check($sformatf("rst%0d_done", s),  32'(d), 0);
      end
      reset_n = 1'b1;
      @(negedge clock);

      run_burst(0, 4'd1, 1'b0, -1, 1'b0);   // 5,4,1,0,9,4
      run_burst(0, 4'd2, 1'b0, -1, 1'b0);
      run_burst(1, 4'd3, 1'b0, -1, 1'b0);   // back-to-back patterns
      run_burst(0, 4'd0, 1'b0, -1, 1'b1);   // 16 instances with stray starts
      run_burst(1, 4'd0, 1'b0, -1, 1'b1);
      run_burst(0, 4'd2, 1'b0, 9, 1'b0);    // reset during P1 of second instance
      run_burst(0, 4'd1, 1'b0, -1, 1'b0);   // reproduces the first burst
`ifdef ERR_INJECT_EN
      run_burst(0, 4'd2, 1'b1, -1, 1'b0);
`endif
      for (int r = 0; r < 20; r++) begin
`ifdef ERR_INJECT_EN
         inj = 1'($urandom_range(0, 1));
`else
         inj = 1'b0;
`endif
         run_burst(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), inj, -1, 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
